// File: rtl/string_feeder.sv
// Byte-buffer streamer: bytes are loaded into a local buffer while idle and then
// presented to a matcher one per cycle. The first PAT_LEN bytes are flagged as
// pattern bytes (EN); the rest are flagged as search bytes (EN_A). HOLD stalls
// the stream.
module string_feeder #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          WR_EN,
  input  logic [AW-1:0] WR_ADDR,
  input  logic [7:0]    WR_DATA,
  input  logic          START,
  input  logic [AW:0]   LEN,
  input  logic [AW:0]   PAT_LEN,
  input  logic          HOLD,
  output logic          EN,
  output logic          EN_A,
  output logic [7:0]    STRING,
  output logic          BUSY,
  output logic          DONE
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    FIN
  } state_t;

  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  state_t      state, state_d;
  logic [7:0]  buffer [DEPTH];
  logic [AW:0] ptr, ptr_d;
  logic [AW:0] len_q, len_d;
  logic [AW:0] pat_q, pat_d;
  logic [7:0]  string_d;
  logic        en_d, en_a_d, busy_d, done_d;
  logic        pat_byte;

  // Buffer writes are accepted only while idle; reset blocks the write but never clears contents.
  always_ff @(posedge CLK) begin
    if (RST && state == IDLE && WR_EN) begin
      buffer[WR_ADDR] <= WR_DATA;
    end
  end

  // Next-state and next-output logic for the streaming FSM.
  always_comb begin
    state_d  = state;
    ptr_d    = ptr;
    len_d    = len_q;
    pat_d    = pat_q;
    string_d = STRING;
    en_d     = EN;
    en_a_d   = EN_A;
    busy_d   = BUSY;
    done_d   = 1'b0;
    pat_byte = (ptr < pat_q);
    unique case (state)
      IDLE: begin
        if (START && LEN != '0) begin
          len_d   = LEN;
          pat_d   = PAT_LEN;
          ptr_d   = '0;
          busy_d  = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (HOLD) begin
          en_d   = 1'b0;
          en_a_d = 1'b0;
        end else begin
          string_d = buffer[ptr[AW-1:0]];
          en_d     = pat_byte;
          en_a_d   = ~pat_byte;
          ptr_d    = ptr + PTR_ONE;
          if (ptr == len_q - PTR_ONE) begin
            state_d = FIN;
          end
        end
      end
      FIN: begin
        en_d    = 1'b0;
        en_a_d  = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state  <= IDLE;
      ptr    <= '0;
      len_q  <= '0;
      pat_q  <= '0;
      STRING <= '0;
      EN     <= 1'b0;
      EN_A   <= 1'b0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
    end else begin
      state  <= state_d;
      ptr    <= ptr_d;
      len_q  <= len_d;
      pat_q  <= pat_d;
      STRING <= string_d;
      EN     <= en_d;
      EN_A   <= en_a_d;
      BUSY   <= busy_d;
      DONE   <= done_d;
    end
  end

endmodule

// File: tb/tb_string_feeder.sv
// Self-checking bench for string_feeder: a per-cycle vector table for the
// directed scenarios, hand sequences for reset/abort, and randomized streams
// checked against a buffer-array reference model.
module tb_string_feeder;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       WR_EN = 1'b0;
  logic [4:0] WR_ADDR = '0;
  logic [7:0] WR_DATA = '0;
  logic       START = 1'b0;
  logic [5:0] LEN = '0;
  logic [5:0] PAT_LEN = '0;
  logic       HOLD = 1'b0;
  logic       EN, EN_A, BUSY, DONE;
  logic [7:0] STRING;

  string_feeder #(.DEPTH(32), .AW(5)) dut (
    .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
    .START(START), .LEN(LEN), .PAT_LEN(PAT_LEN), .HOLD(HOLD),
    .EN(EN), .EN_A(EN_A), .STRING(STRING), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst, we;
    logic [4:0] wa;
    logic [7:0] wd;
    logic       st;
    logic [5:0] ln, pt;
    logic       h;
    logic       e_en, e_ena;
    logic [7:0] e_str;
    logic       e_busy, e_done;
  } vec_t;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [7:0]  mdl [32];
  logic [7:0]  exp_str;
  vec_t        vecs [25];

  function automatic vec_t v(input logic rst, input logic we, input logic [4:0] wa,
                             input logic [7:0] wd, input logic st, input logic [5:0] ln,
                             input logic [5:0] pt, input logic h, input logic e_en,
                             input logic e_ena, input logic [7:0] e_str,
                             input logic e_busy, input logic e_done);
    vec_t r;
    r.rst = rst; r.we = we; r.wa = wa; r.wd = wd; r.st = st; r.ln = ln; r.pt = pt;
    r.h = h; r.e_en = e_en; r.e_ena = e_ena; r.e_str = e_str;
    r.e_busy = e_busy; r.e_done = e_done;
    return r;
  endfunction

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [11:0] pack(input logic en, input logic ena, input logic [7:0] s,
                                       input logic busy, input logic done);
    return {en, ena, s, busy, done};
  endfunction

  // Compare {EN, EN_A, STRING, BUSY, DONE} against the expected tuple.
  task automatic chk(input string name, input logic [11:0] expv);
    logic [11:0] got;
    got = {EN, EN_A, STRING, BUSY, DONE};
    n_cmp++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s: got {en,ena,str,busy,done}=%h expected %h", name, got, expv);
    end
  endtask

  task automatic idle_inputs;
    RST = 1'b1; WR_EN = 1'b0; START = 1'b0; HOLD = 1'b0; LEN = '0; PAT_LEN = '0;
  endtask

  task automatic write_buf(input logic [4:0] a, input logic [7:0] d);
    WR_EN = 1'b1; WR_ADDR = a; WR_DATA = d;
    step;
    WR_EN = 1'b0;
    mdl[a] = d;
  endtask

  // Stream len bytes; the model says byte k is mdl[k], a pattern byte when k < pat,
  // and a held cycle presents nothing new. Noise writes during the stream must be ignored.
  task automatic run_stream(input int len, input int pat, input int hold_pct, input bit noise);
    int k;
    int cyc;
    bit h;
    START = 1'b1; LEN = 6'(len); PAT_LEN = 6'(pat);
    step;
    START = 1'b0;
    chk("start_busy", pack(1'b0, 1'b0, exp_str, 1'b1, 1'b0));
    k = 0;
    cyc = 0;
    while (k < len && cyc < 400) begin
      h = ($urandom_range(99) < hold_pct);
      HOLD = h;
      WR_EN = noise;
      WR_ADDR = 5'($urandom_range(31));
      WR_DATA = 8'($urandom_range(255));
      step;
      cyc++;
      if (h) begin
        chk("stream_hold", pack(1'b0, 1'b0, exp_str, 1'b1, 1'b0));
      end else begin
        exp_str = mdl[k];
        chk("stream_byte", pack(k < pat, k >= pat, exp_str, 1'b1, 1'b0));
        k++;
      end
    end
    if (k < len) begin
      n_cmp++;
      n_bad++;
      $display("FAIL stream_timeout: delivered %0d bytes, required %0d", k, len);
    end
    HOLD = 1'($urandom_range(1));
    step;
    chk("done_pulse", pack(1'b0, 1'b0, exp_str, 1'b0, 1'b1));
    HOLD = 1'b0; WR_EN = 1'b0;
    step;
    chk("done_clear", pack(1'b0, 1'b0, exp_str, 1'b0, 1'b0));
  endtask

  initial begin
    // rst we  wa     wd     st    ln     pt     h   | en   ena   str    busy  done
    vecs[0]  = v(1'b0,1'b0,5'd0,8'h00,1'b0,6'd0,6'd0,1'b0, 1'b0,1'b0,8'h00,1'b0,1'b0);
    vecs[1]  = v(1'b1,1'b1,5'd0,8'h41,1'b0,6'd0,6'd0,1'b0, 1'b0,1'b0,8'h00,1'b0,1'b0);
    vecs[2]  = v(1'b1,1'b1,5'd1,8'h42,1'b0,6'd0,6'd0,1'b0, 1'b0,1'b0,8'h00,1'b0,1'b0);
    vecs[3]  = v(1'b1,1'b1,5'd2,8'h43,1'b0,6'd0,6'd0,1'b0, 1'b0,1'b0,8'h00,1'b0,1'b0);
    vecs[4]  = v(1'b1,1'b0,5'd0,8'h00,1'b1,6'd3,6'd1,1'b0, 1'b0,1'b0,8'h00,1'b1,1'b0);
    vecs[5]  = v(1'b1,1'b0,5'd0,8'h00,1'b0,6'd0,6'd0,1'b0, 1'b1,1'b0,8'h41,1'b1,1'b0);
    vecs[6]  = v(1'b1,1'b0,5'd0,8'h00,1'b0,6'd0,6'd0,1'b0, 1'b0,1'b1,8'h42,1'b1,1'b0);
    vecs[7]  = v(1'b1,1'b0,5'd0,8'h00,1'b0,6'd0,6'd0,1'b0, 1'b0,1'b1,8'h43,1'b1,1'b0);
    vecs[8]  = v(1'b1,1'b0,5'd0,8'h00,1'b0,6'd0,6'd0,1'b0, 1'b0,1'b0,8'h43,1'b0,1'b1);
    vecs[9]  = v(1'b1,1'b0,5'd0,8'h00,1'b1,6'd0,6'd0,1'b0, 1'b0,1'b0,8'h43,1'b0,1'b0);
    vecs[10] = v(1'b1,1'b0,5'd0,8'h00,1'b0,6'd0,6'd0,1'b0, 1'b0,1'b0,8'h43,1'b0,1'b0);
    vecs[11] = v(1'b1,1'b0,5'd0,8'h00,1'b1,6'd3,6'd1,1'b0, 1'b0,1'b0,8'h43,1'b1,1'b0);
    vecs[12] = v(1'b1,1'b0,5'd0,8'h00,1'b0,6'd0,6'd0,1'b0, 1'b1,1'b0,8'h41,1'b1,1'b0);
    vecs[13] = v(1'b1,1'b0,5'd0,8'h00,1'b0,6'd0,6'd0,1'b1, 1'b0,1'b0,8'h41,1'b1,1'b0);
    vecs[14] = v(1'b1,1'b0,5'd0,8'h00,1'b0,6'd0,6'd0,1'b0, 1'b0,1'b1,8'h42,1'b1,1'b0);
    vecs[15] = v(1'b1,1'b0,5'd0,8'h00,1'b0,6'd0,6'd0,1'b0, 1'b0,1'b1,8'h43,1'b1,1'b0);
    vecs[16] = v(1'b1,1'b0,5'd0,8'h00,1'b0,6'd0,6'd0,1'b1, 1'b0,1'b0,8'h43,1'b0,1'b1);
    vecs[17] = v(1'b1,1'b0,5'd0,8'h00,1'b0,6'd0,6'd0,1'b1, 1'b0,1'b0,8'h43,1'b0,1'b0);
    vecs[18] = v(1'b1,1'b1,5'd0,8'h55,1'b1,6'd1,6'd0,1'b0, 1'b0,1'b0,8'h43,1'b1,1'b0);
    vecs[19] = v(1'b1,1'b0,5'd0,8'h00,1'b0,6'd0,6'd0,1'b0, 1'b0,1'b1,8'h55,1'b1,1'b0);
    vecs[20] = v(1'b1,1'b0,5'd0,8'h00,1'b0,6'd0,6'd0,1'b0, 1'b0,1'b0,8'h55,1'b0,1'b1);
    vecs[21] = v(1'b1,1'b0,5'd0,8'h00,1'b1,6'd1,6'd1,1'b0, 1'b0,1'b0,8'h55,1'b1,1'b0);
    vecs[22] = v(1'b1,1'b0,5'd0,8'h00,1'b0,6'd0,6'd0,1'b0, 1'b1,1'b0,8'h55,1'b1,1'b0);
    vecs[23] = v(1'b1,1'b0,5'd0,8'h00,1'b0,6'd0,6'd0,1'b0, 1'b0,1'b0,8'h55,1'b0,1'b1);
    vecs[24] = v(1'b1,1'b0,5'd0,8'h00,1'b0,6'd0,6'd0,1'b0, 1'b0,1'b0,8'h55,1'b0,1'b0);

    for (int i = 0; i < 25; i++) begin
      RST = vecs[i].rst; WR_EN = vecs[i].we; WR_ADDR = vecs[i].wa; WR_DATA = vecs[i].wd;
      START = vecs[i].st; LEN = vecs[i].ln; PAT_LEN = vecs[i].pt; HOLD = vecs[i].h;
      step;
      chk($sformatf("vec%0d", i), pack(vecs[i].e_en, vecs[i].e_ena, vecs[i].e_str,
                                       vecs[i].e_busy, vecs[i].e_done));
    end
    idle_inputs;
    exp_str = 8'h55;

    // Fill the whole buffer so every streamed byte is known to the model.
    for (int i = 0; i < 32; i++) begin
      write_buf(5'(i), 8'($urandom_range(255)));
    end

    // Reset two edges into a LEN=3 stream, with START/WR_EN/HOLD asserted alongside.
    START = 1'b1; LEN = 6'd3; PAT_LEN = 6'd1;
    step;
    START = 1'b0;
    chk("abort_start", pack(1'b0, 1'b0, exp_str, 1'b1, 1'b0));
    step;
    exp_str = mdl[0];
    chk("abort_byte0", pack(1'b1, 1'b0, exp_str, 1'b1, 1'b0));
    RST = 1'b0; START = 1'b1; LEN = 6'd1; WR_EN = 1'b1; WR_ADDR = 5'd0;
    WR_DATA = ~mdl[0]; HOLD = 1'b1;
    step;
    exp_str = 8'h00;
    chk("abort_reset", pack(1'b0, 1'b0, 8'h00, 1'b0, 1'b0));
    idle_inputs;
    step;
    chk("abort_no_done1", pack(1'b0, 1'b0, 8'h00, 1'b0, 1'b0));
    step;
    chk("abort_no_done2", pack(1'b0, 1'b0, 8'h00, 1'b0, 1'b0));
    run_stream(1, 1, 0, 1'b0);

    // Full-depth stream of pattern bytes with write noise, then a search-only re-read.
    run_stream(32, 40, 0, 1'b1);
    run_stream(32, 0, 0, 1'b0);

    // Randomized streams with holds and ignored writes.
    for (int it = 0; it < 25; it++) begin
      for (int w = 0; w < int'($urandom_range(3)); w++) begin
        write_buf(5'($urandom_range(31)), 8'($urandom_range(255)));
      end
      run_stream(int'($urandom_range(1, 32)), int'($urandom_range(40)), 30,
                 1'($urandom_range(1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/string_feeder.md
STRING_FEEDER -- requirements
Module: string_feeder

Interface
REQ-001 The module SHALL have parameter DEPTH, default 32, meaning the byte-buffer entry count.
REQ-002 The module SHALL have parameter AW, default 5, meaning the buffer address width (log2 DEPTH).
REQ-003 The module SHALL have port CLK  input  1  system clock; all logic on the rising edge.
REQ-004 The module SHALL have port RST  input  1  reset, synchronous, active-low.
REQ-005 The module SHALL have port WR_EN  input  1  buffer write strobe.
REQ-006 The module SHALL have port WR_ADDR  input  AW  buffer write address.
REQ-007 The module SHALL have port WR_DATA  input  8  buffer write byte.
REQ-008 The module SHALL have port START  input  1  begin streaming; sampled in IDLE only.
REQ-009 The module SHALL have port LEN  input  AW+1  total bytes to stream, 0..DEPTH, sampled with START.
REQ-010 The module SHALL have port PAT_LEN  input  AW+1  leading bytes sent as pattern bytes, sampled with START.
REQ-011 The module SHALL have port HOLD  input  1  matcher stall request.
REQ-012 The module SHALL have port EN  output  1  pattern-load strobe to matcher.
REQ-013 The module SHALL have port EN_A  output  1  search strobe to matcher.
REQ-014 The module SHALL have port STRING  output  8  byte to matcher.
REQ-015 The module SHALL have port BUSY  output  1  stream in progress.
REQ-016 The module SHALL have port DONE  output  1  one-cycle end-of-stream pulse.

Function
REQ-017 The module SHALL implement states IDLE, SEND and FIN; all outputs SHALL be registered.
REQ-018 In IDLE, WR_EN=1 SHALL write WR_DATA to buffer[WR_ADDR] at the clock edge; WR_EN SHALL be ignored in SEND and FIN.
REQ-019 In IDLE, START=1 with LEN!=0 SHALL latch LEN and PAT_LEN, clear the pointer to 0, enter SEND and set BUSY=1 at that edge.
REQ-020 START with LEN=0, or START outside IDLE, SHALL be ignored with no output change.
REQ-021 A write and START in the same IDLE cycle SHALL both take effect, and the stream SHALL carry the newly written byte.
REQ-022 In SEND with HOLD=0, each edge SHALL load STRING=buffer[ptr], EN=(ptr<PAT_LEN_q), EN_A=~EN, then ptr+1.
REQ-023 PAT_LEN_q>=LEN_q SHALL send all bytes with EN=1; PAT_LEN_q=0 SHALL send all bytes with EN_A=1.
REQ-024 In SEND with HOLD=1, EN and EN_A SHALL be 0 and STRING and ptr SHALL hold; the withheld byte SHALL be presented on the first edge after HOLD falls.
REQ-025 Exactly one of EN/EN_A SHALL be high per delivered byte; they SHALL never be high together.
REQ-026 Latency: START sampled at edge t0 SHALL give byte k on outputs after edge t0+1+k when HOLD=0 throughout.
REQ-027 After the edge presenting byte LEN_q-1, the FSM SHALL enter FIN.
REQ-028 The edge leaving FIN SHALL clear EN and EN_A, set DONE=1, BUSY=0 and return to IDLE; DONE SHALL clear on the following edge.
REQ-029 HOLD SHALL have no effect in FIN or IDLE.
REQ-030 START SHALL be accepted in the cycle DONE=1.
REQ-031 STRING SHALL retain the last byte sent after the stream ends.
REQ-032 The pointer SHALL never wrap, since LEN is at most DEPTH; LEN=DEPTH SHALL send buffer[0..DEPTH-1] once.

Reset
REQ-033 On an edge with RST=0, the module SHALL set state=IDLE, ptr=0, EN=0, EN_A=0, STRING=8'h00, BUSY=0 and DONE=0.
REQ-034 Reset SHALL NOT clear buffer contents.
REQ-035 Reset mid-SEND SHALL abort the stream with no DONE pulse.
REQ-036 RST=0 SHALL override START, WR_EN and HOLD.

Verification
REQ-037 Verification SHALL cover: write buffer[0..2]=41,42,43; START with LEN=3, PAT_LEN=1 at t0 -> after t0+1 STRING=41, EN=1; after t0+2 STRING=42, EN_A=1; after t0+3 STRING=43, EN_A=1; after t0+4 DONE=1, BUSY=0.
REQ-038 Verification SHALL cover: same setup, HOLD=1 during the cycle before t0+2 -> at t0+2 EN=EN_A=0 and STRING=41; at t0+3 STRING=42, EN_A=1; DONE after t0+5.
REQ-039 Verification SHALL cover: LEN=32, PAT_LEN=40 -> 32 bytes with EN=1, EN_A never 1, one DONE pulse.
REQ-040 Verification SHALL cover: LEN=0 START -> BUSY stays 0 and no DONE pulse; WR_EN during SEND -> buffer unchanged when read back by a second stream.
REQ-041 Verification SHALL cover: RST=0 at t0+2 of a LEN=3 stream -> all outputs 0 next edge, no DONE; a re-START with LEN=1 streams the preserved buffer[0].
REQ-042 Verification SHALL cover: START in the DONE cycle -> next stream's first byte after the following edge, no idle gap beyond one cycle.
